// File: rtl/dec_scan_pkg.sv
// Shared types and constants for the decoder scan sequencer.
// Optional BLANK state is used only when SCAN_BLANK_GAP_EN is defined.
package dec_scan_pkg;

    localparam int unsigned IDX_W = 3;

    localparam logic [IDX_W-1:0] IDX_FIRST_UP = 3'd0;
    localparam logic [IDX_W-1:0] IDX_FIRST_DN = 3'd7;

    typedef enum logic [1:0] {IDLE, RUN, BLANK} state_e;

    // Wraps naturally mod 8, so the terminal->first wrap needs no special case.
    function automatic logic [IDX_W-1:0] idx_step(input logic [IDX_W-1:0] i,
                                                  input logic down);
        return down ? i - 3'd1 : i + 3'd1;
    endfunction

    function automatic logic idx_terminal(input logic [IDX_W-1:0] i, input logic down);
        return down ? (i == IDX_FIRST_UP) : (i == IDX_FIRST_DN);
    endfunction

endpackage

// File: rtl/dec_scan_tick.sv
// Dwell counter: counts 0..DWELL-1 while cnt_en is high, flags the last count
// on expire and self-clears; clr forces it back to zero.
module dec_scan_tick #(
    parameter int unsigned DWELL   = 4,
    parameter int unsigned DWELL_W = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic cnt_en,
    output logic expire
);

    localparam logic [DWELL_W-1:0] LAST = DWELL_W'(DWELL - 1);

    generate
        if (DWELL < 1 || 64'(DWELL) > (64'd1 << DWELL_W)) begin : g_bad_dwell
            $error("dec_scan_tick: DWELL out of range 1..2**DWELL_W");
        end
    endgenerate

    logic [DWELL_W-1:0] cnt_q;

    assign expire = cnt_en && (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (cnt_en) begin
            cnt_q <= expire ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/dec_scan_seq.sv
// Scan sequencer feeding a 3-to-8 decoder: steps idx through all 8 lines with a
// programmable dwell. Define SCAN_BLANK_GAP_EN to insert a 1-cycle en=0 gap per step.
module dec_scan_seq
    import dec_scan_pkg::*;
#(
    parameter int unsigned DWELL   = 4,
    parameter int unsigned DWELL_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic             mode,
    output logic [IDX_W-1:0] idx,
    output logic             en,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             dir_q, dir_d;
    logic             mode_q, mode_d;
    logic             en_q, busy_q, done_q, done_d;
    logic             clr, expire;

    dec_scan_tick #(
        .DWELL   (DWELL),
        .DWELL_W (DWELL_W)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .cnt_en (state_q == RUN),
        .expire (expire)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        clr     = 1'b0;
        unique case (state_q)
            IDLE: begin
                clr = 1'b1;
                if (start && !stop) begin
                    dir_d   = dir;
                    mode_d  = mode;
                    idx_d   = dir ? IDX_FIRST_DN : IDX_FIRST_UP;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    clr     = 1'b1;
                    state_d = IDLE;
                end else if (expire) begin
                    done_d = idx_terminal(idx_q, dir_q);
                    if (idx_terminal(idx_q, dir_q) && mode_q) begin
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_step(idx_q, dir_q);
`ifdef SCAN_BLANK_GAP_EN
                        state_d = BLANK;
`endif
                    end
                end
            end
`ifdef SCAN_BLANK_GAP_EN
            BLANK: begin
                clr     = 1'b1;
                state_d = stop ? IDLE : RUN;
            end
`endif
            default: begin
                clr     = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // en/busy come from the next state so they align with idx in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= IDX_FIRST_UP;
            dir_q   <= 1'b0;
            mode_q  <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            en_q    <= (state_d == RUN);
            busy_q  <= (state_d != IDLE);
            done_q  <= done_d;
        end
    end

    assign idx  = idx_q;
    assign en   = en_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_dec_scan_seq.sv
// Directed bench for dec_scan_seq with DWELL=4, 2 and 1 instances.
// Expectations follow SCAN_BLANK_GAP_EN when it is defined.
module tb_dec_scan_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       st4, sp4, dr4, md4, en4, by4, dn4;
    logic [2:0] ix4;
    logic       st2, sp2, dr2, md2, en2, by2, dn2;
    logic [2:0] ix2;
    logic       st1, sp1, dr1, md1, en1, by1, dn1;
    logic [2:0] ix1;

    int n_pass  = 0;
    int n_total = 0;

    dec_scan_seq #(.DWELL(4), .DWELL_W(8)) u4 (
        .clk(clk), .rst_n(rst_n), .start(st4), .stop(sp4), .dir(dr4), .mode(md4),
        .idx(ix4), .en(en4), .busy(by4), .done(dn4)
    );
    dec_scan_seq #(.DWELL(2), .DWELL_W(8)) u2 (
        .clk(clk), .rst_n(rst_n), .start(st2), .stop(sp2), .dir(dr2), .mode(md2),
        .idx(ix2), .en(en2), .busy(by2), .done(dn2)
    );
    dec_scan_seq #(.DWELL(1), .DWELL_W(8)) u1 (
        .clk(clk), .rst_n(rst_n), .start(st1), .stop(sp1), .dir(dr1), .mode(md1),
        .idx(ix1), .en(en1), .busy(by1), .done(dn1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Vectors below are {idx[2:0], en, busy, done}.
    task automatic test_reset();
        n_total++;
        if ({ix4, en4, by4, dn4, ix2, en2, by2, dn2, ix1, en1, by1, dn1} !== 18'd0)
            $display("FAIL reset_state got=%b want=%b",
                     {ix4, en4, by4, dn4, ix2, en2, by2, dn2, ix1, en1, by1, dn1}, 18'd0);
        else n_pass++;
        rst_n = 1'b1;
        step();
        dr4 = 1'b0; md4 = 1'b1; st4 = 1'b1;
        step();
        st4 = 1'b0;
`ifdef SCAN_BLANK_GAP_EN
        repeat (25) step();
`else
        repeat (20) step();
`endif
        n_total++;
        if ({ix4, en4, by4, dn4} !== 6'b101_110)
            $display("FAIL reset_prerun got=%b want=%b", {ix4, en4, by4, dn4}, 6'b101_110);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({ix4, en4, by4, dn4} !== 6'b000_000)
            $display("FAIL reset_async got=%b want=%b", {ix4, en4, by4, dn4}, 6'b000_000);
        else n_pass++;
        step();
        rst_n = 1'b1;
        step();
        n_total++;
        if ({ix4, en4, by4, dn4} !== 6'b000_000)
            $display("FAIL reset_release got=%b want=%b", {ix4, en4, by4, dn4}, 6'b000_000);
        else n_pass++;
    endtask

    // Up, single pass, DWELL=4; disturb toggles start/dir/mode mid-run.
    task automatic test_single_up(input bit disturb);
        logic [2:0] e;
        dr4 = 1'b0; md4 = 1'b1; st4 = 1'b1;
        step();
        st4 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            for (int p = 0; p < 4; p++) begin
                if (disturb && k == 1 && p == 1) begin
                    st4 = 1'b1; dr4 = 1'b1; md4 = 1'b0;
                end
                if (disturb && k == 4 && p == 0) begin
                    st4 = 1'b0; dr4 = 1'b0; md4 = 1'b1;
                end
                e = 3'(k);
                n_total++;
                if ({ix4, en4, by4, dn4} !== {e, 3'b110})
                    $display("FAIL single_up d=%0d k=%0d p=%0d got=%b want=%b",
                             disturb, k, p, {ix4, en4, by4, dn4}, {e, 3'b110});
                else n_pass++;
                step();
            end
`ifdef SCAN_BLANK_GAP_EN
            if (k < 7) begin
                e = 3'(k + 1);
                n_total++;
                if ({ix4, en4, by4, dn4} !== {e, 3'b010})
                    $display("FAIL single_up_blank k=%0d got=%b want=%b",
                             k, {ix4, en4, by4, dn4}, {e, 3'b010});
                else n_pass++;
                step();
            end
`endif
        end
        n_total++;
        if ({ix4, en4, by4, dn4} !== 6'b111_001)
            $display("FAIL single_up_done got=%b want=%b", {ix4, en4, by4, dn4}, 6'b111_001);
        else n_pass++;
        step();
        n_total++;
        if ({ix4, en4, by4, dn4} !== 6'b111_000)
            $display("FAIL single_up_after got=%b want=%b", {ix4, en4, by4, dn4}, 6'b111_000);
        else n_pass++;
    endtask

    task automatic test_stop();
        bit saw = 1'b0;
        dr4 = 1'b0; md4 = 1'b1; st4 = 1'b1;
        step();
        st4 = 1'b0;
        repeat (9) step();
        n_total++;
        if ({ix4, by4, dn4} !== 5'b010_10)
            $display("FAIL stop_pre got=%b want=%b", {ix4, by4, dn4}, 5'b010_10);
        else n_pass++;
        sp4 = 1'b1;
        step();
        sp4 = 1'b0;
        n_total++;
        if ({ix4, en4, by4, dn4} !== 6'b010_000)
            $display("FAIL stop_idle got=%b want=%b", {ix4, en4, by4, dn4}, 6'b010_000);
        else n_pass++;
        for (int i = 0; i < 40; i++) begin
            saw = saw | dn4 | by4 | en4;
            step();
        end
        n_total++;
        if (saw !== 1'b0) $display("FAIL stop_quiet got=%b want=0", saw);
        else n_pass++;
        st4 = 1'b1; sp4 = 1'b1;
        step();
        n_total++;
        if ({ix4, en4, by4, dn4} !== 6'b010_000)
            $display("FAIL start_stop_idle got=%b want=%b", {ix4, en4, by4, dn4}, 6'b010_000);
        else n_pass++;
        step();
        st4 = 1'b0; sp4 = 1'b0;
        n_total++;
        if ({ix4, en4, by4, dn4} !== 6'b010_000)
            $display("FAIL start_stop_idle2 got=%b want=%b", {ix4, en4, by4, dn4}, 6'b010_000);
        else n_pass++;
    endtask

    // Down, continuous, DWELL=2, three passes then stop.
    task automatic test_continuous_down();
        logic [2:0] e;
        logic       d;
        dr2 = 1'b1; md2 = 1'b0; st2 = 1'b1;
        step();
        st2 = 1'b0;
        for (int pass = 0; pass < 3; pass++) begin
            for (int k = 0; k < 8; k++) begin
                for (int p = 0; p < 2; p++) begin
                    e = 3'(7 - k);
`ifdef SCAN_BLANK_GAP_EN
                    d = 1'b0;
`else
                    d = (pass > 0 && k == 0 && p == 0);
`endif
                    n_total++;
                    if ({ix2, en2, by2, dn2} !== {e, 2'b11, d})
                        $display("FAIL cont_down pass=%0d k=%0d p=%0d got=%b want=%b",
                                 pass, k, p, {ix2, en2, by2, dn2}, {e, 2'b11, d});
                    else n_pass++;
                    step();
                end
`ifdef SCAN_BLANK_GAP_EN
                e = 3'(7 - k) - 3'd1;
                d = (k == 7);
                n_total++;
                if ({ix2, en2, by2, dn2} !== {e, 2'b01, d})
                    $display("FAIL cont_down_blank pass=%0d k=%0d got=%b want=%b",
                             pass, k, {ix2, en2, by2, dn2}, {e, 2'b01, d});
                else n_pass++;
                step();
`endif
            end
        end
        sp2 = 1'b1;
        step();
        sp2 = 1'b0;
        n_total++;
        if ({en2, by2, dn2} !== 3'b000)
            $display("FAIL cont_down_stop got=%b want=%b", {en2, by2, dn2}, 3'b000);
        else n_pass++;
    endtask

    task automatic test_dwell1();
        logic [2:0] e;
        dr1 = 1'b0; md1 = 1'b1; st1 = 1'b1;
        step();
        st1 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            e = 3'(k);
            n_total++;
            if ({ix1, en1, by1, dn1} !== {e, 3'b110})
                $display("FAIL dwell1 k=%0d got=%b want=%b", k, {ix1, en1, by1, dn1}, {e, 3'b110});
            else n_pass++;
            step();
`ifdef SCAN_BLANK_GAP_EN
            if (k < 7) begin
                e = 3'(k + 1);
                n_total++;
                if ({ix1, en1, by1, dn1} !== {e, 3'b010})
                    $display("FAIL dwell1_blank k=%0d got=%b want=%b",
                             k, {ix1, en1, by1, dn1}, {e, 3'b010});
                else n_pass++;
                step();
            end
`endif
        end
        n_total++;
        if ({ix1, en1, by1, dn1} !== 6'b111_001)
            $display("FAIL dwell1_done got=%b want=%b", {ix1, en1, by1, dn1}, 6'b111_001);
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        {st4, sp4, dr4, md4} = 4'b0;
        {st2, sp2, dr2, md2} = 4'b0;
        {st1, sp1, dr1, md1} = 4'b0;
        step();
        step();
        test_reset();
        test_single_up(1'b0);
        step();
        test_stop();
        step();
        test_single_up(1'b1);
        test_continuous_down();
        test_dwell1();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
